// File: rtl/answer_keypad_encoder.sv
// rtl/answer_keypad_encoder.sv - 9-button answer pad: synchronise, debounce, one-hot pulse, key code, multi-press flag (optional KEYPAD_LAST_KEY_EN adds last_key)
module answer_keypad_encoder #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [8:0] btn,
   output logic [8:0] joy_out,
   output logic [3:0] key_code,
   output logic       multi_err,
`ifdef KEYPAD_LAST_KEY_EN
   output logic       busy,
   output logic [3:0] last_key
`else
   output logic       busy
`endif
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      DEBOUNCE     = 2'd1,
      FIRE         = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [8:0]       sync1_q, sync2_q;
   logic [8:0]       s;
   state_t           state_q, state_d;
   logic [8:0]       pat_q, pat_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [8:0]       joy_q, joy_d;
   logic [3:0]       code_q, code_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             pat_onehot;
   logic [3:0]       pat_code;

   assign s = sync2_q;

   // Two-stage synchroniser for the asynchronous button inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
      end
   end

   // State, pattern, counter and registered output flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pat_q   <= '0;
         cnt_q   <= '0;
         joy_q   <= '0;
         code_q  <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         cnt_q   <= cnt_d;
         joy_q   <= joy_d;
         code_q  <= code_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic: debounce the press, fire once, then debounce the release
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (s != '0) begin
               pat_d   = s;
               cnt_d   = CNT_ONE;
               state_d = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (s == '0) begin
               cnt_d   = CNT_ZERO;
               state_d = IDLE;
            end else if (s != pat_q) begin
               pat_d = s;
               cnt_d = CNT_ONE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = FIRE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         FIRE: begin
            cnt_d   = CNT_ZERO;
            state_d = WAIT_RELEASE;
         end
         WAIT_RELEASE: begin
            if (s != '0) begin
               cnt_d = CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Pattern classification: one-hot test and 1-based key number
   always_comb begin
      pat_onehot = (pat_d != '0) && ((pat_d & (pat_d - 9'd1)) == '0);
      pat_code   = 4'd0;
      for (int i = 0; i < 9; i++) begin
         if (pat_d[i]) begin
            pat_code = 4'(i + 1);
         end
      end
   end

   // Output decode from the upcoming state so outputs are registered yet aligned with FIRE
   always_comb begin
      joy_d  = '0;
      code_d = 4'd0;
      err_d  = 1'b0;
      busy_d = (state_d != IDLE);
      if (state_d == FIRE) begin
         if (pat_onehot) begin
            joy_d  = pat_d;
            code_d = pat_code;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   assign joy_out   = joy_q;
   assign key_code  = code_q;
   assign multi_err = err_q;
   assign busy      = busy_q;

`ifdef KEYPAD_LAST_KEY_EN
   logic [3:0] last_key_q, last_key_d;

   // Hold the last legal answer for continuous display
   always_comb begin
      last_key_d = last_key_q;
      if ((state_d == FIRE) && pat_onehot) begin
         last_key_d = pat_code;
      end
   end

   // Last-key display register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_key_q <= 4'd0;
      end else begin
         last_key_q <= last_key_d;
      end
   end

   assign last_key = last_key_q;
`endif

endmodule
